// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift/lui sequencer.
// Cut-through behaviour is selected with the SHIFT_SEQ_CUT_THROUGH_EN macro in the top.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_LUI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int LUI_SHIFT = 16;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to STEP bits; reports how many bits it consumed.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  op_e          sel,
  input  logic [N-1:0] din,
  input  logic [4:0]   remaining,
  output logic [N-1:0] dout,
  output logic [4:0]   used
);

  always_comb begin
    used = (remaining < 5'(STEP)) ? remaining : 5'(STEP);
    case (sel)
      OP_SLL:  dout = din << used;
      OP_SRL:  dout = din >> used;
      OP_SRA:  dout = $signed(din) >>> used;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_lui_sequencer.sv
// Multi-cycle sll/srl/sra/lui unit with valid/ready handshakes on both sides.
// Define SHIFT_SEQ_CUT_THROUGH_EN to accept a new request on the response handshake edge.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready=1
//   SHIFT | stepping the result by up to STEP bits per cycle
//   DONE  | result presented until the consumer takes it
module shift_lui_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_sel,
  input  logic [4:0]   req_shamt,
  input  logic [N-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_data,
  output logic         busy
);

  state_e       state_q, state_d;
  op_e          sel_q, sel_d;
  logic [N-1:0] result_q, result_d;
  logic [4:0]   rem_q, rem_d;

  logic [N-1:0] step_out;
  logic [4:0]   step_used;
  logic         accept;
  logic         resp_fire;

  shift_step #(.N(N), .STEP(STEP)) u_shift_step (
    .sel       (sel_q),
    .din       (result_q),
    .remaining (rem_q),
    .dout      (step_out),
    .used      (step_used)
  );

  // Outputs are forced to their reset values while rst is high.
  always_comb begin
    req_ready = rst || (state_q == IDLE);
`ifdef SHIFT_SEQ_CUT_THROUGH_EN
    if (state_q == DONE && resp_ready) req_ready = 1'b1;
`endif
  end

  assign resp_valid = !rst && (state_q == DONE);
  assign resp_data  = resp_valid ? result_q : '0;
  assign busy       = !rst && (state_q != IDLE);
  assign accept     = !rst && req_valid && req_ready;
  assign resp_fire  = resp_valid && resp_ready;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    result_d = result_q;
    rem_d    = rem_q;

    case (state_q)
      SHIFT: begin
        result_d = step_out;
        rem_d    = rem_q - step_used;
        if (rem_q == step_used) state_d = DONE;
      end
      DONE: begin
        if (resp_fire) state_d = IDLE;
      end
      default: ;
    endcase

    // Loading a new request wins over the DONE->IDLE return (cut-through).
    if (accept) begin
      sel_d = op_e'(req_sel);
      if (op_e'(req_sel) == OP_LUI) begin
        result_d = req_b << LUI_SHIFT;
        rem_d    = '0;
        state_d  = DONE;
      end else if (req_shamt == 5'd0) begin
        result_d = req_b;
        rem_d    = '0;
        state_d  = DONE;
      end else begin
        result_d = req_b;
        rem_d    = req_shamt;
        state_d  = SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= OP_SLL;
      result_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      rem_q    <= rem_d;
    end
  end

endmodule
